// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch controller.
// LOAD: a byte-serial loader fills instruction memory from address 0 upward.
// RUN:  the CPU fetches 32-bit little-endian words with one cycle of latency.
//       Illegal addresses raise a one-cycle fault pulse.
module imem_fetch_ctrl #(
    parameter int          A_length = 12,
    parameter int          D_length = 8,
    parameter logic [31:0] BASE     = 32'hBFC00000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    input  logic [D_length-1:0] ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    input  logic                reload,
    input  logic [31:0]         pc,
    input  logic                fetch_req,
    input  logic                fetch_stall,
    input  logic                flush,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic                fetch_fault,
    output logic [A_length-1:0] mem_A,
    output logic                mem_we,
    output logic [D_length-1:0] mem_WD,
    input  logic [31:0]         mem_RD,
    output logic [A_length:0]   load_count,
    output logic                running
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Count value of the beat that writes the top byte, and the saturated count.
    localparam logic [A_length:0] CNT_LAST = {1'b0, {A_length{1'b1}}};
    localparam logic [A_length:0] CNT_FULL = {1'b1, {A_length{1'b0}}};

    state_t              state_q, state_d;
    logic [A_length:0]   load_count_q, load_count_d;
    logic [31:0]         instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                fetch_fault_q, fetch_fault_d;

    logic                in_load;
    logic                beat;
    logic                pc_legal;

    assign in_load  = (state_q == S_LOAD);
    assign beat     = ld_valid & in_load;
    assign pc_legal = (pc[31:A_length] == BASE[31:A_length]) && (pc[1:0] == 2'b00);

    // Memory port: loader drives address/data in LOAD, the CPU pc drives the address in RUN.
    always_comb begin
        ld_ready = in_load;
        running  = ~in_load;
        mem_we   = beat;
        mem_WD   = beat ? ld_data : '0;
        mem_A    = in_load ? load_count_q[A_length-1:0] : pc[A_length-1:0];
    end

    assign load_count  = load_count_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;

    // Next-state logic: loader progress in LOAD, fetch capture with flush > stall > request priority in RUN.
    always_comb begin
        state_d       = state_q;
        load_count_d  = load_count_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = 1'b0;

        if (in_load) begin
            instr_valid_d = 1'b0;
            if (beat) begin
                if (load_count_q != CNT_FULL) begin
                    load_count_d = load_count_q + 1'b1;
                end
                // The top-address beat ends the load even without ld_last, so nothing wraps.
                if (ld_last || (load_count_q == CNT_LAST)) begin
                    state_d = S_RUN;
                end
            end
        end else begin
            if (reload) begin
                state_d       = S_LOAD;
                load_count_d  = '0;
                instr_valid_d = 1'b0;
            end else if (flush) begin
                // Drop the held word and any fetch issued this cycle, fault included.
                instr_valid_d = 1'b0;
            end else if (fetch_stall) begin
                instr_valid_d = instr_valid_q;
            end else if (fetch_req) begin
                if (pc_legal) begin
                    instr_d       = mem_RD;
                    instr_valid_d = 1'b1;
                end else begin
                    instr_valid_d = 1'b0;
                    fetch_fault_d = 1'b1;
                end
            end else begin
                instr_valid_d = 1'b0;
            end
        end
    end

    // State and output registers; reset abandons any load or fetch in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_LOAD;
            load_count_q  <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          reload;
    logic [31:0]   pc;
    logic          fetch_req;
    logic          fetch_stall;
    logic          flush;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          fetch_fault;
    logic [AW-1:0] mem_A;
    logic          mem_we;
    logic [7:0]    mem_WD;
    logic [31:0]   mem_RD;
    logic [AW:0]   load_count;
    logic          running;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .reload      (reload),
        .pc          (pc),
        .fetch_req   (fetch_req),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault),
        .mem_A       (mem_A),
        .mem_we      (mem_we),
        .mem_WD      (mem_WD),
        .mem_RD      (mem_RD),
        .load_count  (load_count),
        .running     (running)
    );

    // Byte-wide instruction memory with combinational 32-bit little-endian read.
    logic [7:0] mem [0:4095];
    always @(posedge clk) if (mem_we) mem[mem_A] <= mem_WD;
    always_comb begin
        logic [AW-1:0] a1, a2, a3;
        a1 = mem_A + 12'd1;
        a2 = mem_A + 12'd2;
        a3 = mem_A + 12'd3;
        mem_RD = {mem[a3], mem[a2], mem[a1], mem[mem_A]};
    end

    typedef struct {
        logic        rl, rq, st, fl;
        logic [31:0] pc;
        logic [31:0] e_instr;
        logic        e_valid, e_fault, e_run;
        logic [12:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(logic rl, logic rq, logic st, logic fl, logic [31:0] p,
                                logic [31:0] ei, logic ev, logic ef, logic er, logic [12:0] ec);
        vec_t v;
        v.rl = rl; v.rq = rq; v.st = st; v.fl = fl; v.pc = p;
        v.e_instr = ei; v.e_valid = ev; v.e_fault = ef; v.e_run = er; v.e_cnt = ec;
        return v;
    endfunction

    function automatic logic [7:0] stream_byte(int i);
        logic [7:0] b;
        b = i[7:0];
        return b ^ 8'h5A;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One fetch-side cycle: drive, queue the expectation, compare after the edge.
    task automatic apply_vec(vec_t v);
        vec_t e;
        @(negedge clk);
        reload = v.rl; fetch_req = v.rq; fetch_stall = v.st; flush = v.fl; pc = v.pc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("instr",       instr,               e.e_instr);
        check("instr_valid", 32'(instr_valid),    32'(e.e_valid));
        check("fetch_fault", 32'(fetch_fault),    32'(e.e_fault));
        check("running",     32'(running),        32'(e.e_run));
        check("load_count",  32'(load_count),     32'(e.e_cnt));
        reload = 0; fetch_req = 0; fetch_stall = 0; flush = 0;
    endtask

    task automatic load_byte(logic [7:0] d, logic last, int addr);
        @(negedge clk);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        #1;
        check("ld_we",   32'(mem_we), 32'd1);
        check("ld_addr", 32'(mem_A),  32'(addr));
        check("ld_wd",   32'(mem_WD), 32'(d));
        @(posedge clk);
        #1;
        check("ld_count", 32'(load_count), 32'(addr + 1));
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    initial begin
        logic [7:0] img [8];
        logic [31:0] w0, w1, wtop;
        int errs;
        img = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h93, 8'h00, 8'h50, 8'h00};
        w0 = 32'hDF9B5713;
        w1 = 32'h00500093;

        rst = 1'b1; ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0;
        pc = 0; fetch_req = 0; fetch_stall = 0; flush = 0;
        #1;
        check("rst_ready",   32'(ld_ready),    32'd1);
        check("rst_running", 32'(running),     32'd0);
        check("rst_we",      32'(mem_we),      32'd0);
        check("rst_count",   32'(load_count),  32'd0);
        check("rst_instr",   instr,            32'd0);
        check("rst_valid",   32'(instr_valid), 32'd0);
        check("rst_fault",   32'(fetch_fault), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Eight-byte image with ld_last on the final byte.
        for (int i = 0; i < 8; i++) load_byte(img[i], (i == 7), i);
        check("load8_running", 32'(running),  32'd1);
        check("load8_ready",   32'(ld_ready), 32'd0);
        #1;
        check("run_we", 32'(mem_we), 32'd0);
        check("run_wd", 32'(mem_WD), 32'd0);

        //            rl rq st fl pc             instr  v  f  run cnt
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00004, w1, 1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00000, w0, 1, 0, 1, 8));
        tbl.push_back(mk(0, 0, 0, 0, 32'hBFC00000, w0, 0, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC01000, w0, 0, 1, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00002, w0, 0, 1, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00004, w1, 1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 1, 0, 32'hBFC01000, w1, 1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 1, 0, 32'hBFC00000, w1, 1, 0, 1, 8));
        tbl.push_back(mk(0, 0, 1, 0, 32'hBFC00002, w1, 1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 1, 1, 32'hBFC00000, w1, 0, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00000, w0, 1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 1, 32'hBFC01000, w0, 0, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'h00000000, w0, 0, 1, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00004, w1, 1, 0, 1, 8));
        tbl.push_back(mk(0, 1, 0, 0, 32'hBFC00003, w1, 0, 1, 1, 8));
        tbl.push_back(mk(0, 1, 1, 0, 32'h00000000, w1, 0, 0, 1, 8));
        tbl.push_back(mk(1, 1, 0, 0, 32'hBFC00000, w1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h00000000, w1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'hBFC00000, w1, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i]);

        // Full-depth stream without ld_last.
        errs = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = stream_byte(i); ld_last = 1'b0;
            #1;
            if (!mem_we || mem_A != i[AW-1:0] || mem_WD != stream_byte(i) || !ld_ready) errs++;
        end
        @(posedge clk);
        #1;
        check("stream_beats", 32'(errs),       32'd0);
        check("stream_count", 32'(load_count), 32'd4096);
        check("stream_run",   32'(running),    32'd1);
        check("stream_ready", 32'(ld_ready),   32'd0);
        @(negedge clk);
        ld_data = 8'hEE;
        #1;
        check("extra_we", 32'(mem_we), 32'd0);
        check("extra_wd", 32'(mem_WD), 32'd0);
        @(posedge clk);
        #1;
        check("extra_count", 32'(load_count), 32'd4096);
        ld_valid = 1'b0;
        wtop = {stream_byte(4095), stream_byte(4094), stream_byte(4093), stream_byte(4092)};
        w0   = {stream_byte(3), stream_byte(2), stream_byte(1), stream_byte(0)};
        apply_vec(mk(0, 1, 0, 0, 32'hBFC00FFC, wtop, 1, 0, 1, 4096));
        apply_vec(mk(0, 1, 0, 0, 32'hBFC00000, w0,   1, 0, 1, 4096));
        apply_vec(mk(1, 0, 0, 0, 32'hBFC00000, w0,   0, 0, 0, 0));

        // Reset in the middle of a load, then reload out of RUN.
        for (int i = 0; i < 5; i++) load_byte(8'(i + 1), 1'b0, i);
        check("mid_count", 32'(load_count), 32'd5);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_count",   32'(load_count),  32'd0);
        check("async_instr",   instr,            32'd0);
        check("async_valid",   32'(instr_valid), 32'd0);
        check("async_ready",   32'(ld_ready),    32'd1);
        check("async_running", 32'(running),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        load_byte(8'hAA, 1'b0, 0);
        load_byte(8'hBB, 1'b0, 1);
        load_byte(8'hCC, 1'b0, 2);
        load_byte(8'hDD, 1'b1, 3);
        w1 = {stream_byte(7), stream_byte(6), stream_byte(5), 8'h05};
        apply_vec(mk(0, 1, 0, 0, 32'hBFC00000, 32'hDDCCBBAA, 1, 0, 1, 4));
        apply_vec(mk(0, 1, 0, 0, 32'hBFC00004, w1,           1, 0, 1, 4));
        apply_vec(mk(1, 1, 0, 0, 32'hBFC00000, w1,           0, 0, 0, 0));
        #1;
        check("reload_ready", 32'(ld_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
